// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display datapath.
//   state_t  : converter FSM encoding (IDLE/SHIFT/DONE)
//   BCD_NINE : digit value used when the display saturates
//   pow10    : 10^n, used to derive the display range limit
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: any digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   digit_i : current BCD scratch digit
//   digit_o : corrected digit
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds the per-digit seven-segment decoders; outputs only change on the
// done pulse, so the decoders never see a partially converted value.
//   clk, rst  : clock, synchronous active-high reset
//   start     : conversion request, accepted only in IDLE
//   bin       : unsigned value, captured on the accepted start
//   busy      : conversion in progress
//   done      : one-cycle pulse, bcd/overflow updated
//   bcd       : packed BCD, digit 0 (units) in bcd[3:0]
//   overflow  : last value exceeded the display range (bcd shows all nines)
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SHIFT | W correction+shift steps, cnt counts remaining bits
// DONE  | publish scratch (or all nines) to the output registers
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [63:0] MAXVAL_64 = pow10(DIGITS) - 64'd1;
  // When the whole input range fits on the display the compare is dropped.
  localparam bit          OVF_POSSIBLE = (MAXVAL_64 < (64'd1 << W));
  localparam logic [W:0]  MAXVAL = MAXVAL_64[W:0];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [BW-1:0]   corr;
  logic            ovf_next_q, ovf_next_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            overflow_q, overflow_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (corr[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    ovf_next_d = ovf_next_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d    = bin;
          scratch_d  = '0;
          cnt_d      = CW'(W);
          ovf_next_d = OVF_POSSIBLE && ({1'b0, bin} > MAXVAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Correct first, then shift {scratch, shreg} left; carries out of
        // the top digit only occur for out-of-range values and are dropped.
        scratch_d = {corr[BW-2:0], shreg_q[W-1]};
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d     = 1'b1;
        bcd_d      = ovf_next_q ? {DIGITS{BCD_NINE}} : scratch_q;
        overflow_d = ovf_next_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      scratch_q  <= '0;
      ovf_next_q <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      ovf_next_q <= ovf_next_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int n_checks;
  int n_errors;

  bin_to_bcd_seq #(.W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Starts one conversion from IDLE and follows it to the end.
  // Sample index j = number of edges after the accepting edge.
  task automatic do_conv(input int v, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input bit chk_busy);
    bin   = 14'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_busy) check("busy_first", {31'b0, busy}, 32'd1);
    for (int j = 1; j <= 15; j++) begin
      @(posedge clk); #1;
      if (chk_busy) check("busy_run", {31'b0, busy}, {31'b0, (j <= 14)});
      check("done_timing", {31'b0, done}, {31'b0, (j == 15)});
    end
    check("bcd", {16'b0, bcd}, {16'b0, exp_bcd});
    check("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
    for (int d = 0; d < 4; d++) begin
      check("nibble_le9", {31'b0, (bcd[4*d +: 4] <= 4'd9)}, 32'd1);
    end
    @(posedge clk); #1;
    check("done_width", {31'b0, done}, 32'd0);
    check("bcd_hold", {16'b0, bcd}, {16'b0, exp_bcd});
  endtask

  initial begin
    int v;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_bcd", {16'b0, bcd}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_conv(1234,  16'h1234, 1'b0, 1'b1);
    do_conv(0,     16'h0000, 1'b0, 1'b1);
    do_conv(9999,  16'h9999, 1'b0, 1'b0);
    do_conv(10000, 16'h9999, 1'b1, 1'b0);
    do_conv(16383, 16'h9999, 1'b1, 1'b0);
    do_conv(7,     16'h0007, 1'b0, 1'b0);

    // start held high: a result every 16 cycles; bin wiggle mid-run ignored
    bin   = 14'd42;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 47; c++) begin
      @(posedge clk); #1;
      if (c == 5)  bin = 14'd99;
      if (c == 10) bin = 14'd42;
      check("stream_done", {31'b0, done}, {31'b0, ((c % 16) == 15)});
      if (done) check("stream_bcd", {16'b0, bcd}, 32'h0042);
      if (c == 47) start = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("stream_idle", {31'b0, busy}, 32'd0);

    // reset during SHIFT
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_bcd", {16'b0, bcd}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("abort_no_done", {31'b0, done}, 32'd0);
    end
    do_conv(56, 16'h0056, 1'b0, 1'b1);

    for (int k = 0; k < 2000; k++) begin
      v = int'($urandom_range(0, 16383));
      do_conv(v, ref_bcd(v), (v > 9999), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
